// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared types and helpers for the bit-serial add/subtract sequencer
package serial_add_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
   function automatic int cnt_width(input int width);
      return ($clog2(width) < 1) ? 1 : $clog2(width);
   endfunction
endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: operand and result valid/ready handshake bundle
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;
   modport master (output in_valid, in_a, in_b, in_sub, out_ready,
                   input  in_ready, out_valid, out_sum, out_cout, out_ovf);
   modport slave  (input  in_valid, in_a, in_b, in_sub, out_ready,
                   output in_ready, out_valid, out_sum, out_cout, out_ovf);
endinterface

// File: rtl/full_adder.sv
// full_adder: single-bit full-adder library cell
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencer sharing one full-adder cell, LSB first
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   serial_add_ctrl_if.slave bus
);
   localparam int CNT_W = cnt_width(WIDTH);
   state_e           state, state_d;
   logic [WIDTH-1:0] shift_a, shift_b, sum_q;
   logic [CNT_W-1:0] cnt;
   logic             carry, cout_q, ovf_q, s, co, last;
   full_adder u_fa (.a(shift_a[0]), .b(shift_b[0]), .ci(carry), .s(s), .co(co));
   assign last = cnt == CNT_W'(WIDTH - 1);
   always_comb begin
      state_d = state;
      state_d = (state == IDLE) ? (bus.in_valid ? RUN : IDLE) :
                (state == RUN)  ? (last ? DONE : RUN) :
                (bus.out_ready ? IDLE : DONE);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         shift_a <= '0;
         shift_b <= '0;
         sum_q   <= '0;
         cnt     <= '0;
         carry   <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state <= state_d;
         if (state == IDLE && bus.in_valid) begin
            shift_a <= bus.in_a;
            shift_b <= bus.in_sub ? ~bus.in_b : bus.in_b;
            carry   <= bus.in_sub;
            cnt     <= '0;
         end else if (state == RUN) begin
            // sum bits enter at the MSB so the word is aligned after WIDTH shifts
            sum_q   <= (sum_q >> 1) | (WIDTH'(s) << (WIDTH - 1));
            shift_a <= shift_a >> 1;
            shift_b <= shift_b >> 1;
            carry   <= co;
            cnt     <= cnt + 1'b1;
            if (last) begin
               cout_q <= co;
               ovf_q  <= carry ^ co;
            end
         end
      end
   end
   assign bus.in_ready  = state == IDLE;
   assign bus.out_valid = state == DONE;
   assign bus.out_sum   = sum_q;
   assign bus.out_cout  = cout_q;
   assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and scoreboard checks of the serial add/subtract sequencer
module tb_serial_add_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_add_ctrl_if #(.WIDTH(8))  b8 ();
   serial_add_ctrl_if #(.WIDTH(1))  b1 ();
   serial_add_ctrl_if #(.WIDTH(13)) b13 ();
   serial_add_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
   serial_add_ctrl #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(b1));
   serial_add_ctrl #(.WIDTH(13)) dut13 (.clk(clk), .rst_n(rst_n), .bus(b13));

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

   // drives one operation on the 8-bit instance; returns at the negedge where out_valid is seen
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                      output logic [7:0] sum, output logic co, output logic ov, output int lat);
      int guard = 0;
      while (!b8.in_ready && guard < 40) begin @(negedge clk); guard++; end
      b8.in_a = a; b8.in_b = b; b8.in_sub = sub; b8.in_valid = 1'b1;
      @(negedge clk);
      b8.in_valid = 1'b0;
      lat = 0;
      while (!b8.out_valid && lat < 40) begin @(negedge clk); lat++; end
      sum = b8.out_sum; co = b8.out_cout; ov = b8.out_ovf;
   endtask

   task automatic op13(input logic [12:0] a, input logic [12:0] b, input logic sub,
                       output logic [12:0] sum, output logic co, output logic ov, output int lat);
      int guard = 0;
      while (!b13.in_ready && guard < 40) begin @(negedge clk); guard++; end
      b13.in_a = a; b13.in_b = b; b13.in_sub = sub; b13.in_valid = 1'b1;
      @(negedge clk);
      b13.in_valid = 1'b0;
      lat = 0;
      while (!b13.out_valid && lat < 40) begin @(negedge clk); lat++; end
      sum = b13.out_sum; co = b13.out_cout; ov = b13.out_ovf;
   endtask

   task automatic test_reset;
      #3;
      checks++; if (b8.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", b8.in_ready); end
      checks++; if (b8.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", b8.out_valid); end
      checks++; if (b8.out_sum !== 8'h00) begin errors++; $display("FAIL rst_out_sum got %h want 00", b8.out_sum); end
      checks++; if (b8.out_cout !== 1'b0) begin errors++; $display("FAIL rst_out_cout got %b want 0", b8.out_cout); end
      checks++; if (b8.out_ovf !== 1'b0) begin errors++; $display("FAIL rst_out_ovf got %b want 0", b8.out_ovf); end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0) begin errors++; $display("FAIL rst_release got ready=%b valid=%b want 1/0", b8.in_ready, b8.out_valid); end
   endtask

   task automatic test_basic_add;
      logic [7:0] s; logic c, o; int lat;
      b8.out_ready = 1'b1;
      op8(8'h35, 8'h4A, 1'b0, s, c, o, lat);
      checks++; if (lat !== 8) begin errors++; $display("FAIL add_latency got %0d want 8", lat); end
      checks++; if (s !== 8'h7F || c !== 1'b0 || o !== 1'b0) begin errors++; $display("FAIL add_35_4a got %h/%b/%b want 7f/0/0", s, c, o); end
      checks++; if (b8.in_ready !== 1'b0) begin errors++; $display("FAIL add_ready_done got %b want 0", b8.in_ready); end
      @(negedge clk);
      checks++; if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0) begin errors++; $display("FAIL add_return_idle got ready=%b valid=%b want 1/0", b8.in_ready, b8.out_valid); end
   endtask

   task automatic test_add_boundaries;
      logic [7:0] s; logic c, o; int lat;
      op8(8'hFF, 8'h01, 1'b0, s, c, o, lat);
      checks++; if (s !== 8'h00 || c !== 1'b1 || o !== 1'b0) begin errors++; $display("FAIL add_ff_01 got %h/%b/%b want 00/1/0", s, c, o); end
      op8(8'h7F, 8'h01, 1'b0, s, c, o, lat);
      checks++; if (s !== 8'h80 || c !== 1'b0 || o !== 1'b1) begin errors++; $display("FAIL add_7f_01 got %h/%b/%b want 80/0/1", s, c, o); end
   endtask

   task automatic test_subtract;
      logic [7:0] s; logic c, o; int lat;
      op8(8'h10, 8'h20, 1'b1, s, c, o, lat);
      checks++; if (s !== 8'hF0 || c !== 1'b0 || o !== 1'b0) begin errors++; $display("FAIL sub_10_20 got %h/%b/%b want f0/0/0", s, c, o); end
      op8(8'h80, 8'h01, 1'b1, s, c, o, lat);
      checks++; if (s !== 8'h7F || c !== 1'b1 || o !== 1'b1) begin errors++; $display("FAIL sub_80_01 got %h/%b/%b want 7f/1/1", s, c, o); end
   endtask

   task automatic test_backpressure;
      logic [7:0] s; logic c, o; int lat;
      @(negedge clk);
      b8.out_ready = 1'b0;
      op8(8'h12, 8'h34, 1'b0, s, c, o, lat);
      checks++; if (s !== 8'h46) begin errors++; $display("FAIL bp_result got %h want 46", s); end
      for (int i = 0; i < 5; i++) begin
         b8.in_a = 8'($urandom); b8.in_b = 8'($urandom); b8.in_valid = 1'($urandom);
         @(negedge clk);
         checks++; if (b8.out_valid !== 1'b1 || b8.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_hs cycle %0d got valid=%b ready=%b want 1/0", i, b8.out_valid, b8.in_ready); end
         checks++; if (b8.out_sum !== 8'h46 || b8.out_cout !== 1'b0 || b8.out_ovf !== 1'b0) begin errors++; $display("FAIL bp_hold_data cycle %0d got %h/%b/%b want 46/0/0", i, b8.out_sum, b8.out_cout, b8.out_ovf); end
      end
      b8.in_valid = 1'b0;
      b8.out_ready = 1'b1;
      @(negedge clk);
      checks++; if (b8.out_valid !== 1'b0 || b8.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", b8.out_valid, b8.in_ready); end
      checks++; if (b8.out_sum !== 8'h46) begin errors++; $display("FAIL bp_retain got %h want 46", b8.out_sum); end
      @(negedge clk);
      checks++; if (b8.in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_accept got ready=%b want 1", b8.in_ready); end
   endtask

   task automatic test_reset_mid_op;
      logic [7:0] s; logic c, o; int lat;
      b8.in_a = 8'h55; b8.in_b = 8'h66; b8.in_sub = 1'b1; b8.in_valid = 1'b1;
      @(negedge clk);
      b8.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_async got ready=%b valid=%b want 1/0", b8.in_ready, b8.out_valid); end
      checks++; if (b8.out_sum !== 8'h00) begin errors++; $display("FAIL midrst_sum got %h want 00", b8.out_sum); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      op8(8'h01, 8'h01, 1'b0, s, c, o, lat);
      checks++; if (s !== 8'h02 || c !== 1'b0 || o !== 1'b0 || lat !== 8) begin errors++; $display("FAIL midrst_next got %h/%b/%b lat %0d want 02/0/0 lat 8", s, c, o, lat); end
      @(negedge clk);
   endtask

   task automatic test_width1;
      int lat, guard;
      guard = 0;
      b1.out_ready = 1'b1;
      while (!b1.in_ready && guard < 10) begin @(negedge clk); guard++; end
      b1.in_a = 1'b1; b1.in_b = 1'b1; b1.in_sub = 1'b0; b1.in_valid = 1'b1;
      @(negedge clk);
      b1.in_valid = 1'b0;
      lat = 0;
      while (!b1.out_valid && lat < 10) begin @(negedge clk); lat++; end
      checks++; if (lat !== 1) begin errors++; $display("FAIL w1_latency got %0d want 1", lat); end
      // -1 + -1 = -2 leaves the 1-bit signed range, so carry-in 0 vs carry-out 1 flags overflow
      checks++; if (b1.out_sum !== 1'b0 || b1.out_cout !== 1'b1 || b1.out_ovf !== 1'b1) begin errors++; $display("FAIL w1_add got %b/%b/%b want 0/1/1", b1.out_sum, b1.out_cout, b1.out_ovf); end
      @(negedge clk);
      checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL w1_idle got %b want 1", b1.in_ready); end
   endtask

   task automatic test_random8;
      logic [7:0] a, b, bb, s, es; logic sub, c, o, eo; logic [8:0] full; int lat, c0;
      repeat (2) @(negedge clk);
      b8.out_ready = 1'b1;
      c0 = cyc;
      for (int i = 0; i < 1000; i++) begin
         a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
         bb = sub ? ~b : b;
         full = {1'b0, a} + {1'b0, bb} + {8'd0, sub};
         es = full[7:0];
         eo = (a[7] == bb[7]) && (es[7] != a[7]);
         op8(a, b, sub, s, c, o, lat);
         checks++; if (s !== es || c !== full[8] || o !== eo || lat !== 8) begin errors++; $display("FAIL rnd8 op %0d a=%h b=%h sub=%b got %h/%b/%b lat %0d want %h/%b/%b lat 8", i, a, b, sub, s, c, o, lat, es, full[8], eo); end
      end
      checks++; if (cyc - c0 !== 1000 * 10 - 1) begin errors++; $display("FAIL rnd8_throughput got %0d want %0d", cyc - c0, 1000 * 10 - 1); end
   endtask

   task automatic test_random13;
      logic [12:0] a, b, bb, s, es; logic sub, c, o, eo; logic [13:0] full; int lat, c0;
      repeat (2) @(negedge clk);
      b13.out_ready = 1'b1;
      c0 = cyc;
      for (int i = 0; i < 1000; i++) begin
         a = 13'($urandom); b = 13'($urandom); sub = 1'($urandom);
         bb = sub ? ~b : b;
         full = {1'b0, a} + {1'b0, bb} + {13'd0, sub};
         es = full[12:0];
         eo = (a[12] == bb[12]) && (es[12] != a[12]);
         op13(a, b, sub, s, c, o, lat);
         checks++; if (s !== es || c !== full[13] || o !== eo || lat !== 13) begin errors++; $display("FAIL rnd13 op %0d a=%h b=%h sub=%b got %h/%b/%b lat %0d want %h/%b/%b lat 13", i, a, b, sub, s, c, o, lat, es, full[13], eo); end
      end
      checks++; if (cyc - c0 !== 1000 * 15 - 1) begin errors++; $display("FAIL rnd13_throughput got %0d want %0d", cyc - c0, 1000 * 15 - 1); end
   endtask

   initial begin
      b8.in_valid = 1'b0;  b8.in_a = '0;  b8.in_b = '0;  b8.in_sub = 1'b0;  b8.out_ready = 1'b0;
      b1.in_valid = 1'b0;  b1.in_a = '0;  b1.in_b = '0;  b1.in_sub = 1'b0;  b1.out_ready = 1'b0;
      b13.in_valid = 1'b0; b13.in_a = '0; b13.in_b = '0; b13.in_sub = 1'b0; b13.out_ready = 1'b0;
      test_reset();
      test_basic_add();
      test_add_boundaries();
      test_subtract();
      test_backpressure();
      test_reset_mid_op();
      test_width1();
      test_random8();
      test_random13();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
